// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the instruction memory request, keeps the PC,
// and loads the IF/ID register, with a one-entry hold buffer for ID back-pressure.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branchTaken,
   input  logic [31:0] branchTarget,
   input  logic        jump,
   input  logic [25:0] jumpAddr,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemReady,
   input  logic [31:0] imemData,
   output logic [31:0] instruction32,
   output logic [31:0] pcPlus4,
   output logic        instrValid,
   output logic [31:0] pc,
   output logic [15:0] fetchCount
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   logic [1:0]  state;
   logic [31:0] pcReg;
   logic [31:0] instrReg;
   logic [31:0] pcPlus4Reg;
   logic        validReg;
   logic [15:0] countReg;
   logic [31:0] holdBuf;
   logic        redirect;
   logic [31:0] redirectTarget;
   logic [31:0] pcNext;
   logic        unusedBranchLsbs;

   // Branch wins over jump; the jump keeps the region bits of the instruction in ID.
   assign redirect         = branchTaken | jump;
   assign redirectTarget   = branchTaken ? {branchTarget[31:2], 2'b00}
                                         : {pcPlus4Reg[31:28], jumpAddr, 2'b00};
   assign pcNext           = pcReg + 32'd4;
   assign unusedBranchLsbs = ^branchTarget[1:0];

   assign imemReq       = (state == FETCH);
   assign imemAddr      = pcReg;
   assign pc            = pcReg;
   assign instruction32 = instrReg;
   assign pcPlus4       = pcPlus4Reg;
   assign instrValid    = validReg;
   assign fetchCount    = countReg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pcReg      <= RESET_PC;
         instrReg   <= 32'h0;
         pcPlus4Reg <= 32'h0;
         validReg   <= 1'b0;
         countReg   <= 16'h0;
         holdBuf    <= 32'h0;
      end else if (state != IDLE && redirect) begin
         // Redirect beats stall: flush IF/ID and drop any buffered word.
         state    <= FETCH;
         pcReg    <= redirectTarget;
         instrReg <= 32'h0;
         validReg <= 1'b0;
         holdBuf  <= 32'h0;
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               if (imemReady && !stall) begin
                  instrReg   <= imemData;
                  pcPlus4Reg <= pcNext;
                  validReg   <= 1'b1;
                  pcReg      <= pcNext;
                  countReg   <= countReg + 16'd1;
               end else if (imemReady) begin
                  holdBuf <= imemData;
                  state   <= HOLD;
               end else if (!stall) begin
                  instrReg <= 32'h0;
                  validReg <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  instrReg   <= holdBuf;
                  pcPlus4Reg <= pcNext;
                  validReg   <= 1'b1;
                  pcReg      <= pcNext;
                  countReg   <= countReg + 16'd1;
                  holdBuf    <= 32'h0;
                  state      <= FETCH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h00000000, the PC value loaded on reset.
REQ-002 The block SHALL have a single clock `clk` and a synchronous, active-high reset `reset`, with the following ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  ID stage cannot accept; hold IF/ID.
- branchTaken  in  1  redirect to branchTarget.
- branchTarget  in  32  branch destination.
- jump  in  1  redirect to jump target.
- jumpAddr  in  26  J-type address field from ID.
- imemReq  out  1  fetch request.
- imemAddr  out  32  fetch address (current PC).
- imemReady  in  1  imemData valid this cycle.
- imemData  in  32  fetched word.
- instruction32  out  32  IF/ID instruction register, feeds ID.
- pcPlus4  out  32  IF/ID PC+4 of instruction32.
- instrValid  out  1  IF/ID holds a real instruction.
- pc  out  32  current fetch PC.
- fetchCount  out  16  instructions delivered to IF/ID, wraps.

Function
REQ-003 The FSM SHALL have three states, IDLE, FETCH and HOLD; IDLE SHALL last exactly one cycle after reset, then go to FETCH.
REQ-004 imemReq SHALL be 1 only in FETCH; imemAddr SHALL equal pc at all times.
REQ-005 In FETCH with imemReady=1 and stall=0, the block SHALL load the IF/ID register on that edge: instruction32<=imemData, pcPlus4<=pc+4, instrValid<=1, pc<=pc+4, fetchCount<=fetchCount+1.
REQ-006 In FETCH with imemReady=1 and stall=1, the block SHALL:
- capture imemData into a one-entry hold buffer, with pc unchanged;
- keep IF/ID unchanged;
- go to HOLD.
REQ-007 In FETCH with imemReady=0, stall=0 SHALL load a bubble (instruction32=0, instrValid=0, pcPlus4 unchanged) and stall=1 SHALL leave IF/ID unchanged; pc SHALL be unchanged in both cases.
REQ-008 In HOLD with stall=1, the block SHALL keep everything unchanged; with stall=0 it SHALL do the following on one edge, then return to FETCH:
- move the buffer into IF/ID with instrValid=1;
- set pc<=pc+4 and increment fetchCount.
REQ-009 A redirect (branchTaken=1 or jump=1) in FETCH or HOLD SHALL, on the same edge:
- load pc with the target;
- flush IF/ID to instruction32=0 and instrValid=0;
- discard the hold buffer and any outstanding request;
- go to FETCH.
REQ-010 Redirect priority SHALL be reset > redirect > stall; redirect SHALL override stall.
REQ-011 If branchTaken and jump are both 1, branchTaken SHALL win.
REQ-012 Branch target SHALL be {branchTarget[31:2],2'b00}; jump target SHALL be {pcPlus4[31:28],jumpAddr,2'b00}, using the registered pcPlus4 output.
REQ-013 A redirect in IDLE SHALL be ignored.
REQ-014 While imemReq=1 and imemReady=0, imemAddr SHALL stay stable unless a redirect occurs.
REQ-015 PC arithmetic SHALL be 32-bit modulo: 32'hFFFFFFFC+4 = 32'h00000000; fetchCount SHALL wrap 16'hFFFF to 16'h0000.

Reset
REQ-016 While reset=1 at a rising edge, the block SHALL set pc=RESET_PC, instruction32=0, pcPlus4=0, instrValid=0, fetchCount=0, hold buffer empty, and state IDLE, so imemReq=0 the following cycle.
REQ-017 Reset SHALL take effect mid-operation (in FETCH or HOLD, or together with a redirect or stall) and SHALL override all other inputs.

Verification
REQ-018 Sequential fetch: reset, then imemReady=1 with data 0x20080001, 0x20090002 -> after IDLE, instruction32 = those words on consecutive cycles; pcPlus4 = 4 then 8; fetchCount = 1 then 2.
REQ-019 Wait states: imemReady=0 for 2 cycles at pc=8 -> two bubbles (instrValid=0); imemAddr=8 held; the word arrives on the third cycle.
REQ-020 Stall and hold: stall=1 while imemReady=1 at pc=8 -> state HOLD, IF/ID unchanged, imemReq=0; stall=0 -> buffered word appears and pc=12.
REQ-021 Redirect: branchTaken=1 with branchTarget=0x00000043 during stall -> pc=0x00000040, instrValid=0 next cycle; jump=1 in the same cycle is ignored.
REQ-022 Jump: pcPlus4=0x30000010, jumpAddr=0x0000100 -> pc=0x30000400.
REQ-023 Reset in HOLD and PC wrap: reset asserted in HOLD -> all outputs at reset values, buffer lost; with RESET_PC=32'hFFFFFFFC, the first delivered pcPlus4=0.
